run_detector: RTL and testbench
===============================

RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 SHALL have parameter RUN_LEN, default 2, the number of consecutive identical bits that form a detection (legal range 2..16).
REQ-002 SHALL have parameter MEALY, default 1: 1 = Mealy timing, 0 = Moore timing.
REQ-003 SHALL have parameter CNT_W, default 8, the width of the detection counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 inp  input  1  serial data bit; sampled only when en=1.
REQ-007 en  input  1  sample qualifier; when en=0, inp is ignored.
REQ-008 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled together with inp.
REQ-009 clear  input  1  synchronous clear of det_cnt.
REQ-010 outp  output  1  one-cycle detection pulse.
REQ-011 run_val  output  1  bit value (0 or 1) of the most recently detected run.
REQ-012 det_cnt  output  CNT_W  saturating count of detections.

Function
REQ-013 SHALL implement the states IDLE (no bit history) and RUN (tracking last bit `last` and run length `len`, 1..RUN_LEN).
REQ-014 SHALL, when en=1 in IDLE, go to RUN with last<=inp and len<=1; no detection can occur from IDLE.
REQ-015 SHALL, when en=1 in RUN with inp!=last, load last<=inp and len<=1.
REQ-016 SHALL, when en=1 in RUN with inp==last, set len<=min(len+1, RUN_LEN); "hit" = (len+1 >= RUN_LEN).
REQ-017 SHALL, on a hit with overlap=0, go to IDLE so the next run starts fresh (e.g. 0000 with RUN_LEN=2 gives 2 detections).
REQ-018 SHALL, on a hit with overlap=1, stay in RUN with len saturated, so every further matching bit is a hit (0000 with RUN_LEN=2 gives 3 detections).
REQ-019 SHALL hold state, len and last unchanged while en=0.
REQ-020 SHALL, with MEALY=1, register outp=1 on the hit edge: outp is high in the cycle immediately after the accepting sample and low otherwise.
REQ-021 SHALL, with MEALY=0, latch the hit into a DET flag and derive outp from that registered flag: outp is high exactly 2 cycles after the accepting sample, for one cycle.
REQ-022 SHALL update run_val<=last on every hit (same edge as the hit), and hold it otherwise.
REQ-023 SHALL increment det_cnt by 1 per hit and saturate at 2^CNT_W-1 with no wrap.
REQ-024 SHALL make clear take priority over a simultaneous hit, leaving det_cnt=0 on that edge; outp still pulses for that hit.
REQ-025 SHALL let a change of overlap between samples affect only subsequent hits.

Reset
REQ-026 SHALL, on rst=1, immediately force state=IDLE, len=0, last=0, the DET flag=0, outp=0, run_val=0 and det_cnt=0, regardless of clk.
REQ-027 SHALL discard any partial run when reset occurs mid-run; the first hit after release needs RUN_LEN fresh matching samples.

Configuration
REQ-028 SHALL gate the detection counter with macro RUN_DETECTOR_CNT_EN.
- Defined: det_cnt and clear behave per REQ-023/024.
- Undefined: no counter flops; det_cnt is tied to 0 and clear is ignored.
- All other behaviour is identical in both builds.

Structure
REQ-029 SHALL take from shared package run_det_pkg:
- the state typedef (IDLE, RUN);
- the function computing the len width, $clog2(RUN_LEN+1);
- constants MAX_RUN_LEN=16 and MIN_RUN_LEN=2.
REQ-030 SHALL be a single module with no sub-modules; parameter range violations SHALL be caught by an elaboration-time check.

Verification
REQ-031 RUN_LEN=2, MEALY=1, overlap=0, en=1; inp 0,0,1,1,0,1 -> outp high the cycle after samples 2 and 4; run_val 0 then 1; det_cnt=2.
REQ-032 RUN_LEN=3, MEALY=1; inp 1,1,1,1,1 -> overlap=1 gives 3 pulses and det_cnt=3; overlap=0 gives 1 pulse and det_cnt=1.
REQ-033 RUN_LEN=2, MEALY=0 vs MEALY=1; inp 1,1 -> outp pulse 2 cycles after the second sample (Moore) vs 1 cycle after (Mealy).
REQ-034 en toggled 1,0,0,1 with inp=0 at each en=1 sample (RUN_LEN=2) -> a single hit; outp low during the en=0 gap.
REQ-035 CNT_W=2, overlap=1, 6 hits -> det_cnt saturates at 3; clear coincident with a hit -> det_cnt=0 and outp still pulses.
REQ-036 rst asserted between clock edges after inp 1,1 (RUN_LEN=3) -> outputs 0 immediately; a following single 1 gives no detection.

Source files
------------

// File: rtl/run_det_pkg.sv
// ----------------------------------------------------------------------------
// run_det_pkg
// Shared definitions for the run detector:
//   run_state_t  - FSM state encoding (IDLE: no bit history, RUN: tracking).
//   MIN_RUN_LEN  - smallest legal run length.
//   MAX_RUN_LEN  - largest legal run length.
//   len_width()  - width of the run-length register for a given RUN_LEN.
// ----------------------------------------------------------------------------
package run_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  localparam int MIN_RUN_LEN = 2;
  localparam int MAX_RUN_LEN = 16;

  // The length register must hold values 0..run_len inclusive.
  function automatic int len_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_detector.sv
// ----------------------------------------------------------------------------
// run_detector
// Detects runs of RUN_LEN consecutive identical bits on a qualified serial
// input, in either overlapping or non-overlapping mode, with Mealy- or
// Moore-style output timing.
//
// Parameters:
//   RUN_LEN  number of identical bits forming a detection (2..16)
//   MEALY    1: outp one cycle after the accepting sample
//            0: outp two cycles after the accepting sample
//   CNT_W    width of the detection counter
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   inp      serial data bit, sampled when en=1
//   en       sample qualifier
//   overlap  1: overlapping detection, 0: restart after each detection
//   clear    synchronous clear of det_cnt (wins over a coincident hit)
//   outp     one-cycle detection pulse
//   run_val  bit value of the most recently detected run
//   det_cnt  saturating detection count
//
// Build option:
//   RUN_DETECTOR_CNT_EN  when defined, det_cnt counts hits and clear is
//                        honoured; when undefined, det_cnt is tied to zero,
//                        no counter flops exist and clear is ignored.
// ----------------------------------------------------------------------------
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int MEALY   = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             en,
  input  logic             overlap,
  input  logic             clear,
  output logic             outp,
  output logic             run_val,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int                LEN_W     = len_width(RUN_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(RUN_LEN);
  localparam logic [LEN_W:0]    LEN_MAX_X = (LEN_W + 1)'(RUN_LEN);

  // Elaboration-time parameter checks.
  generate
    if (RUN_LEN < MIN_RUN_LEN || RUN_LEN > MAX_RUN_LEN) begin : g_bad_run_len
      $error("run_detector: RUN_LEN must be within 2..16");
    end
    if (MEALY != 0 && MEALY != 1) begin : g_bad_mealy
      $error("run_detector: MEALY must be 0 or 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("run_detector: CNT_W must be at least 1");
    end
  endgenerate

  run_state_t       r_state;
  logic             r_last;
  logic [LEN_W-1:0] r_len;
  logic             r_det;
  logic             r_outp;
  logic             r_run_val;

  logic             w_match;
  logic             w_hit;
  logic [LEN_W:0]   w_len_p1;
  logic [LEN_W-1:0] w_len_nxt;

  // A hit is a matching sample that brings the run to RUN_LEN. The extra bit
  // on w_len_p1 keeps len+1 exact when len is already saturated.
  always_comb begin
    w_match   = (r_state == RUN) && en && (inp == r_last);
    w_len_p1  = (LEN_W + 1)'(r_len) + (LEN_W + 1)'(1);
    w_hit     = w_match && (w_len_p1 >= LEN_MAX_X);
    w_len_nxt = w_hit ? LEN_MAX : w_len_p1[LEN_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b0;
      r_len     <= '0;
      r_det     <= 1'b0;
      r_outp    <= 1'b0;
      r_run_val <= 1'b0;
    end else begin
      // Moore timing goes through the DET flag, adding one cycle.
      r_det  <= w_hit;
      r_outp <= (MEALY != 0) ? w_hit : r_det;
      if (w_hit) begin
        r_run_val <= r_last;
      end

      if (en) begin
        case (r_state)
          IDLE: begin
            r_state <= RUN;
            r_last  <= inp;
            r_len   <= LEN_ONE;
          end
          RUN: begin
            if (inp != r_last) begin
              r_last <= inp;
              r_len  <= LEN_ONE;
            end else if (w_hit && !overlap) begin
              // Non-overlapping: forget the run so the next one starts fresh.
              r_state <= IDLE;
              r_len   <= '0;
            end else begin
              r_len <= w_len_nxt;
            end
          end
        endcase
      end
    end
  end

  assign outp    = r_outp;
  assign run_val = r_run_val;

`ifdef RUN_DETECTOR_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a coincident hit; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign det_cnt = r_cnt;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear;
  assign det_cnt        = '0;
`endif

endmodule

// File: tb/tb_run_detector.sv
// ----------------------------------------------------------------------------
// tb_run_detector
// Four run_detector instances share one stimulus stream:
//   a: RUN_LEN=2 MEALY=1 CNT_W=8     b: RUN_LEN=3 MEALY=1 CNT_W=8
//   c: RUN_LEN=2 MEALY=0 CNT_W=2     d: RUN_LEN=3 MEALY=0 CNT_W=2
// A window-based reference model predicts every output each cycle; directed
// sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_run_detector;

`ifdef RUN_DETECTOR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inp = 1'b0;
  logic en = 1'b0;
  logic overlap = 1'b0;
  logic clear = 1'b0;

  logic outp_a, outp_b, outp_c, outp_d;
  logic rv_a, rv_b, rv_c, rv_d;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c, cnt_d;

  int n_cmp = 0;
  int n_bad = 0;

  initial forever #5 clk = ~clk;

  run_detector #(.RUN_LEN(2), .MEALY(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .inp(inp), .en(en), .overlap(overlap), .clear(clear),
    .outp(outp_a), .run_val(rv_a), .det_cnt(cnt_a));
  run_detector #(.RUN_LEN(3), .MEALY(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .inp(inp), .en(en), .overlap(overlap), .clear(clear),
    .outp(outp_b), .run_val(rv_b), .det_cnt(cnt_b));
  run_detector #(.RUN_LEN(2), .MEALY(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .inp(inp), .en(en), .overlap(overlap), .clear(clear),
    .outp(outp_c), .run_val(rv_c), .det_cnt(cnt_c));
  run_detector #(.RUN_LEN(3), .MEALY(0), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .inp(inp), .en(en), .overlap(overlap), .clear(clear),
    .outp(outp_d), .run_val(rv_d), .det_cnt(cnt_d));

  function automatic int rl(input int c);
    return (c == 1 || c == 3) ? 3 : 2;
  endfunction
  function automatic bit is_mealy(input int c);
    return (c < 2);
  endfunction
  function automatic int cnt_max(input int c);
    return (c < 2) ? 255 : 3;
  endfunction

  function automatic logic [31:0] d_outp(input int c);
    case (c)
      0: return 32'(outp_a);
      1: return 32'(outp_b);
      2: return 32'(outp_c);
      default: return 32'(outp_d);
    endcase
  endfunction
  function automatic logic [31:0] d_rv(input int c);
    case (c)
      0: return 32'(rv_a);
      1: return 32'(rv_b);
      2: return 32'(rv_c);
      default: return 32'(rv_d);
    endcase
  endfunction
  function automatic logic [31:0] d_cnt(input int c);
    case (c)
      0: return 32'(cnt_a);
      1: return 32'(cnt_b);
      2: return 32'(cnt_c);
      default: return 32'(cnt_d);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: keep a window of the samples accepted since the last
  // fresh start; a hit is when the newest RUN_LEN of them are all equal.
  bit [15:0] m_win  [4];
  int        m_fill [4];
  bit        m_det  [4];
  bit        m_outp [4];
  bit        m_rv   [4];
  int        m_cnt  [4];

  always @(posedge clk or posedge rst) begin
    bit hit;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        m_win[c] = '0; m_fill[c] = 0; m_det[c] = 0;
        m_outp[c] = 0; m_rv[c] = 0; m_cnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        hit = 1'b0;
        if (en) begin
          m_win[c] = {m_win[c][14:0], inp};
          if (m_fill[c] < 16) m_fill[c]++;
          if (m_fill[c] >= rl(c)) begin
            hit = 1'b1;
            for (int k = 0; k < rl(c); k++)
              if (m_win[c][k] != inp) hit = 1'b0;
          end
          if (hit && !overlap) m_fill[c] = 0;
        end
        m_outp[c] = is_mealy(c) ? hit : m_det[c];
        m_det[c]  = hit;
        if (hit) m_rv[c] = inp;
        if (clear) m_cnt[c] = 0;
        else if (hit && m_cnt[c] < cnt_max(c)) m_cnt[c]++;
      end
    end
  end

  // Every-cycle compare, 2 time units after the active edge.
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("outp[%0d]", c), d_outp(c), 32'(m_outp[c]));
      chk($sformatf("run_val[%0d]", c), d_rv(c), 32'(m_rv[c]));
      chk($sformatf("det_cnt[%0d]", c), d_cnt(c), CNT_ON ? 32'(m_cnt[c]) : 32'd0);
    end
  end

  // Drive one cycle of inputs on the falling edge, return just after the
  // following rising edge.
  task automatic drive(input logic i, input logic e, input logic o, input logic c);
    @(negedge clk);
    inp = i; en = e; overlap = o; clear = c;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clear = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int pulses;
  logic prev_bit;

  initial begin
    logic [5:0] s31;
    logic [5:0] o31;
    logic [5:0] v31;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outp", 32'(outp_a), 32'd0);
    chk("reset_run_val", 32'(rv_a), 32'd0);
    chk("reset_det_cnt", 32'(cnt_a), 32'd0);

    // Runs 00 and 11 detected, non-overlapping, RUN_LEN=2.
    s31 = 6'b101100;   // samples from bit0: 0,0,1,1,0,1
    o31 = 6'b001010;   // outp after edges 1..6: 0,1,0,1,0,0
    v31 = 6'b111000;   // run_val after edges: 0,0,0,1,1,1
    for (int k = 0; k < 6; k++) begin
      drive(s31[k], 1'b1, 1'b0, 1'b0);
      chk($sformatf("seq_outp_%0d", k), 32'(outp_a), 32'(o31[k]));
      chk($sformatf("seq_run_val_%0d", k), 32'(rv_a), 32'(v31[k]));
    end
    chk("seq_det_cnt", 32'(cnt_a), CNT_ON ? 32'd2 : 32'd0);

    // Five ones, RUN_LEN=3: overlapping vs non-overlapping.
    do_reset();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      pulses += int'(outp_b);
    end
    chk("ovl_pulses", 32'(pulses), 32'd3);
    chk("ovl_det_cnt", 32'(cnt_b), CNT_ON ? 32'd3 : 32'd0);
    do_reset();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      pulses += int'(outp_b);
    end
    chk("novl_pulses", 32'(pulses), 32'd1);
    chk("novl_det_cnt", 32'(cnt_b), CNT_ON ? 32'd1 : 32'd0);

    // Moore (c) vs Mealy (a) timing on 1,1.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("moore_e1", 32'(outp_c), 32'd0);
    chk("mealy_e1", 32'(outp_a), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("moore_e2", 32'(outp_c), 32'd0);
    chk("mealy_e2", 32'(outp_a), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("moore_e3", 32'(outp_c), 32'd1);
    chk("mealy_e3", 32'(outp_a), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("moore_e4", 32'(outp_c), 32'd0);

    // en gap: en 1,0,0,1 with inp=0.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_e1", 32'(outp_a), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_e2", 32'(outp_a), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_e3", 32'(outp_a), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_e4", 32'(outp_a), 32'd1);

    // Saturation on CNT_W=2 and clear coincident with a hit.
    do_reset();
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sat_det_cnt", 32'(cnt_c), CNT_ON ? 32'd3 : 32'd0);
    chk("sat_wide_cnt", 32'(cnt_a), CNT_ON ? 32'd6 : 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_det_cnt", 32'(cnt_a), 32'd0);
    chk("clr_outp_mealy", 32'(outp_a), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_det_cnt_moore", 32'(cnt_c), 32'd0);
    chk("clr_outp_moore", 32'(outp_c), 32'd1);

    // Asynchronous reset mid-cycle, then a partial run must not complete.
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_outp", 32'(outp_b), 32'd1);
    #1;
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_outp", 32'(outp_b), 32'd0);
    chk("async_run_val", 32'(rv_b), 32'd0);
    chk("async_det_cnt", 32'(cnt_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_rst_1", 32'(outp_b), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_2", 32'(outp_b), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_rst_3", 32'(outp_b), 32'd0);

    // Randomized phase.
    prev_bit = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      logic nb;
      nb = ($urandom_range(0, 3) == 0) ? ~prev_bit : prev_bit;
      prev_bit = nb;
      drive(nb, ($urandom_range(0, 7) != 0), ((n / 16) % 3 != 0),
            ($urandom_range(0, 31) == 0));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
